// File: rtl/transaction_pkg.sv
// Shared definitions for the transaction-layer control FSM: state codes,
// default sizing and the occupancy-width rule.
package transaction_pkg;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam int DEF_NUM_FIFOS = 10;
  localparam int DEF_THRESH_W  = 3;

  // Occupancy counts need one more bit than the watermarks so that a full
  // FIFO can be represented alongside the largest programmable threshold.
  function automatic int cnt_w(input int thresh_w);
    return thresh_w + 1;
  endfunction

endpackage

// File: rtl/fifo_watermark.sv
// Single-FIFO back-pressure flag with high/low watermark hysteresis.
// clear beats force_set beats the hysteresis update; with none of them
// active the flag holds its value.
module fifo_watermark
  import transaction_pkg::*;
#(
  parameter int THRESH_W = DEF_THRESH_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       force_set,
  input  logic [cnt_w(THRESH_W)-1:0] count,
  input  logic [THRESH_W-1:0]        alto,
  input  logic [THRESH_W-1:0]        bajo,
  output logic                       pause
);

  logic w_at_high;
  logic w_at_low;
  logic r_pause;

  // Watermarks are zero-extended to the occupancy width; compares are unsigned.
  assign w_at_high = (count >= {1'b0, alto});
  assign w_at_low  = (count <= {1'b0, bajo});

  // Hysteresis flag: set at/above alto, clear at/below bajo, hold in between.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pause <= 1'b0;
    end else if (clear) begin
      r_pause <= 1'b0;
    end else if (force_set) begin
      r_pause <= 1'b1;
    end else if (enable) begin
      if (w_at_high) begin
        r_pause <= 1'b1;
      end else if (w_at_low) begin
        r_pause <= 1'b0;
      end
    end
  end

  assign pause = r_pause;

endmodule

// File: rtl/transaction_ctrl_fsm.sv
// Transaction-layer control FSM: RESET -> INIT -> IDLE <-> ACTIVE plus a
// sticky ERROR state, watermark latching and per-FIFO pause flags.
// Optional feature macro: TRANSACTION_IDLE_HOLDOFF_EN (ACTIVE->IDLE only
// after HOLDOFF consecutive all-empty cycles).
module transaction_ctrl_fsm
  import transaction_pkg::*;
#(
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int THRESH_W  = DEF_THRESH_W,
  parameter int HOLDOFF   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 init,
  input  logic [THRESH_W-1:0]                  umbral_alto,
  input  logic [THRESH_W-1:0]                  umbral_bajo,
  input  logic [NUM_FIFOS-1:0]                 fifo_empty,
  input  logic [NUM_FIFOS*cnt_w(THRESH_W)-1:0] fifo_count,
  input  logic [NUM_FIFOS-1:0]                 fifo_overflow,
  output logic                                 idle,
  output logic                                 active,
  output logic                                 error,
  output logic [2:0]                           estado,
  output logic [THRESH_W-1:0]                  interno_alto,
  output logic [THRESH_W-1:0]                  interno_bajo,
  output logic [NUM_FIFOS-1:0]                 pause
);

  localparam int CNT_W = cnt_w(THRESH_W);

  if (HOLDOFF < 1) begin : g_holdoff_range
    $error("HOLDOFF must be at least 1");
  end

  logic [2:0]          r_estado;
  logic                r_idle;
  logic                r_active;
  logic                r_error;
  logic [THRESH_W-1:0] r_alto;
  logic [THRESH_W-1:0] r_bajo;

  logic [2:0]           w_next;
  logic                 w_all_empty;
  logic                 w_any_ovf;
  logic                 w_drain_done;
  logic                 w_pause_clear;
  logic                 w_pause_force;
  logic                 w_pause_en;
  logic [NUM_FIFOS-1:0] w_pause;

  assign w_all_empty = &fifo_empty;
  assign w_any_ovf   = |fifo_overflow;

`ifdef TRANSACTION_IDLE_HOLDOFF_EN
  localparam int                HOLD_W    = $clog2(HOLDOFF + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLDOFF);

  logic [HOLD_W-1:0] r_hold;

  // Counts consecutive all-empty cycles spent in ACTIVE; zero outside ACTIVE
  // so every entry into ACTIVE starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
    end else if ((r_estado != ST_ACTIVE) || !w_all_empty) begin
      r_hold <= '0;
    end else if (r_hold != HOLD_MAX) begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end

  // This cycle is the HOLDOFF-th consecutive empty one.
  assign w_drain_done = w_all_empty && (r_hold == HOLD_LAST);
`else
  assign w_drain_done = w_all_empty;
`endif

  // Next state: init beats overflow beats the normal sequencing.
  always_comb begin
    w_next = ST_RESET;
    if (init) begin
      w_next = ST_INIT;
    end else if (w_any_ovf && (r_estado != ST_RESET) && (r_estado != ST_INIT)) begin
      w_next = ST_ERROR;
    end else begin
      case (r_estado)
        ST_RESET:  w_next = ST_INIT;
        ST_INIT:   w_next = (umbral_bajo >= umbral_alto) ? ST_ERROR : ST_IDLE;
        ST_IDLE:   w_next = w_all_empty ? ST_IDLE : ST_ACTIVE;
        ST_ACTIVE: w_next = w_drain_done ? ST_IDLE : ST_ACTIVE;
        ST_ERROR:  w_next = ST_ERROR;
        default:   w_next = ST_RESET;
      endcase
    end
  end

  // State and status flags. idle needs a full cycle already spent in IDLE,
  // so it rises one cycle after entering IDLE but falls on the leaving edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= ST_RESET;
      r_idle   <= 1'b0;
      r_active <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_estado <= w_next;
      r_idle   <= (r_estado == ST_IDLE) && (w_next == ST_IDLE);
      r_active <= (w_next == ST_ACTIVE);
      r_error  <= (w_next == ST_ERROR);
    end
  end

  // Watermarks track the programming inputs for as long as we sit in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alto <= '0;
      r_bajo <= '0;
    end else if (r_estado == ST_INIT) begin
      r_alto <= umbral_alto;
      r_bajo <= umbral_bajo;
    end
  end

  // Pause flags: cleared heading into RESET/INIT, forced on in ERROR, and
  // only follow the occupancy while the controller is operational.
  assign w_pause_clear = (w_next == ST_RESET) || (w_next == ST_INIT);
  assign w_pause_force = (w_next == ST_ERROR);
  assign w_pause_en    = (r_estado == ST_IDLE) || (r_estado == ST_ACTIVE);

  for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_wm
    fifo_watermark #(
      .THRESH_W (THRESH_W)
    ) u_wm (
      .clk       (clk),
      .reset     (reset),
      .enable    (w_pause_en),
      .clear     (w_pause_clear),
      .force_set (w_pause_force),
      .count     (fifo_count[gi*CNT_W +: CNT_W]),
      .alto      (r_alto),
      .bajo      (r_bajo),
      .pause     (w_pause[gi])
    );
  end

  assign estado       = r_estado;
  assign idle         = r_idle;
  assign active       = r_active;
  assign error        = r_error;
  assign interno_alto = r_alto;
  assign interno_bajo = r_bajo;
  assign pause        = w_pause;

endmodule
